bnn_digit_encoder: RTL

//  Inverse of the 7-input binary classifier: turns a digit class 0-9 into the 7-bit pattern
//  the classifier decodes to that class. The pattern is the bitwise complement of the class

---
 rtl/bnn_digit_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bnn_digit_encoder.sv
// bnn_digit_encoder
//   Stimulus source for the 7-input binary digit classifier. Turns a class
//   index 0-9 into the 7-bit pattern the classifier decodes back to that class
//   (the complement of the class weight, since a class fires on ~(w ^ in) == 0).
//   Each accepted digit is emitted as a burst of REPEAT words separated by
//   GAP_CYCLES idle cycles. Noise can optionally flip one bit per word.
//
// Parameters
//   REPEAT      words per accepted digit (1..15)
//   GAP_CYCLES  idle cycles between words of one burst (0..255)
//   LFSR_SEED   nonzero reset value of the noise LFSR
//
// Ports
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   digit_in     in   4  class index to encode
//   digit_valid  in   1  digit_in valid
//   digit_ready  out  1  encoder idle and able to take a digit
//   noise_en     in   1  sampled with the digit; flip one bit per word
//   code_out     out  7  pattern for the classifier
//   code_valid   out  1  code_out valid
//   code_ready   in   1  downstream takes code_out
//   bad_digit    out  1  sticky flag, a digit above 9 was accepted
//
// States
//   state     | meaning
//   ST_IDLE   | waiting for a digit, digit_ready high
//   ST_EMIT   | presenting a word, held until code_ready
//   ST_GAP    | idle spacing between words of a burst

module bnn_digit_encoder #(
  parameter int unsigned REPEAT     = 1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       noise_en,
  output logic [6:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       bad_digit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] REP_INIT = 4'(REPEAT - 1);
  // Wraps when GAP_CYCLES is 0, but the gap path is never taken then.
  localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES - 1);

  state_t      state_q,     state_d;
  logic [6:0]  code_q,      code_d;
  logic        noise_q,     noise_d;
  logic [3:0]  rep_cnt_q,   rep_cnt_d;
  logic [7:0]  gap_cnt_q,   gap_cnt_d;
  logic [15:0] lfsr_q,      lfsr_d;
  logic [6:0]  code_out_q,  code_out_d;
  logic        bad_digit_q, bad_digit_d;
  logic [6:0]  flip_mask;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b0000100;
      4'd1:    c = 7'b0010000;
      4'd2:    c = 7'b0100010;
      4'd3:    c = 7'b0010100;
      4'd4:    c = 7'b0110000;
      4'd5:    c = 7'b0100011;
      4'd6:    c = 7'b0000101;
      4'd7:    c = 7'b0100000;
      4'd8:    c = 7'b0001000;
      4'd9:    c = 7'b0010011;
      default: c = 7'b0000000;
    endcase
    return c;
  endfunction

  // LFSR index 7 means "no flip" so roughly one word in eight stays clean.
  always_comb begin
    flip_mask = 7'd0;
    if (lfsr_q[2:0] != 3'd7) begin
      flip_mask = 7'd1 << lfsr_q[2:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    noise_d     = noise_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    code_out_d  = code_out_q;
    bad_digit_d = bad_digit_q;
    // Fibonacci taps 16,14,13,11
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      ST_IDLE: begin
        if (digit_valid && digit_ready) begin
          code_d     = encode(digit_in);
          noise_d    = noise_en;
          rep_cnt_d  = REP_INIT;
          // noise_en is used directly here: the latched copy is not visible yet.
          code_out_d = encode(digit_in) ^ (noise_en ? flip_mask : 7'd0);
          if (digit_in > 4'd9) begin
            bad_digit_d = 1'b1;
          end
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (code_ready) begin
          if (rep_cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            if (GAP_CYCLES == 0) begin
              code_out_d = code_q ^ (noise_q ? flip_mask : 7'd0);
            end else begin
              gap_cnt_d = GAP_INIT;
              state_d   = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          code_out_d = code_q ^ (noise_q ? flip_mask : 7'd0);
          state_d    = ST_EMIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= 7'd0;
      noise_q     <= 1'b0;
      rep_cnt_q   <= 4'd0;
      gap_cnt_q   <= 8'd0;
      lfsr_q      <= LFSR_SEED;
      code_out_q  <= 7'd0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      noise_q     <= noise_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      lfsr_q      <= lfsr_d;
      code_out_q  <= code_out_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  // Gated with rst_n so the source never looks ready while held in reset.
  assign digit_ready = rst_n && (state_q == ST_IDLE);
  assign code_valid  = (state_q == ST_EMIT);
  assign code_out    = code_out_q;
  assign bad_digit   = bad_digit_q;

endmodule
